// File: rtl/sd_spi_command_sequencer.sv
// SD-card SPI-mode command sequencer: decodes parsed commands, tracks card state,
// and streams R1/R7 responses and single-block read data to the SPI transmitter.
module sd_spi_command_sequencer #(
    parameter int DEFAULT_BLOCK_LEN = 512,
    parameter int MAX_BLOCK_LEN     = 2048,
    parameter int NCR_BYTES         = 1,
    parameter int NAC_BYTES         = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_CommandValid,
    input  logic        io_CommandCrcOk,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
    input  logic        io_CsActive,
    output logic [7:0]  io_TxData,
    output logic        io_TxValid,
    input  logic        io_TxReady,
    output logic        io_MemReq,
    output logic [31:0] io_MemAddr,
    input  logic [7:0]  io_MemData,
    input  logic        io_MemAck,
    output logic [11:0] io_BlockLength,
    output logic        io_Idle,
    output logic        io_Busy
);

    typedef enum logic [3:0] {
        S_WAIT,
        S_NCR,
        S_RESP,
        S_R7TAIL,
        S_NAC,
        S_TOKEN,
        S_FETCH,
        S_SEND,
        S_CRC
    } state_t;

    localparam logic [7:0]  LP_NCR     = 8'(NCR_BYTES);
    localparam logic [7:0]  LP_NAC     = 8'(NAC_BYTES);
    localparam logic [31:0] LP_MAX_LEN = 32'(MAX_BLOCK_LEN);
    localparam logic [11:0] LP_DEF_LEN = 12'(DEFAULT_BLOCK_LEN);

    state_t      r_state;
    logic        r_idle;
    logic        r_app;
    logic [11:0] r_blockLen;
    logic [11:0] r_curLen;
    logic [11:0] r_index;
    logic [7:0]  r_count;
    logic [7:0]  r_r1;
    logic        r_isCmd8;
    logic        r_readArmed;
    logic [31:0] r_arg;
    logic [7:0]  r_txData;
    logic        r_txValid;
    logic        r_memReq;
    logic [31:0] r_memAddr;

    logic        w_accept;
    logic [7:0]  w_idleBit;
    logic [7:0]  w_r1;
    logic        w_nextIdle;
    logic        w_nextApp;
    logic        w_lenLoad;
    logic        w_isCmd8;
    logic        w_readArm;

    assign w_accept  = r_txValid & io_TxReady;
    assign w_idleBit = {7'd0, r_idle};

    // Echo-back bytes of R7: two reserved zero bytes, then voltage nibble and check pattern.
    function automatic logic [7:0] r7Byte(input logic [1:0] idx, input logic [11:0] voltArg);
        case (idx)
            2'd2:    r7Byte = {4'h0, voltArg[11:8]};
            2'd3:    r7Byte = voltArg[7:0];
            default: r7Byte = 8'h00;
        endcase
    endfunction

    // A bad CRC leaves every piece of card state untouched, including the app prefix.
    always_comb begin
        w_r1       = 8'h04 | w_idleBit;
        w_nextIdle = r_idle;
        w_nextApp  = 1'b0;
        w_lenLoad  = 1'b0;
        w_isCmd8   = 1'b0;
        w_readArm  = 1'b0;
        if (!io_CommandCrcOk) begin
            w_r1      = 8'h08 | w_idleBit;
            w_nextApp = r_app;
        end else if (io_Command == 6'd0) begin
            w_nextIdle = 1'b1;
            w_r1       = 8'h01;
        end else if (io_Command == 6'd8) begin
            w_r1     = w_idleBit;
            w_isCmd8 = 1'b1;
        end else if (io_Command == 6'd55) begin
            w_nextApp = 1'b1;
            w_r1      = w_idleBit;
        end else if (io_Command == 6'd41 && r_app) begin
            w_nextIdle = 1'b0;
            w_r1       = 8'h00;
        end else if (io_Command == 6'd16) begin
            if (io_CommandArgument == 32'd0 || io_CommandArgument > LP_MAX_LEN) begin
                w_r1 = 8'h40 | w_idleBit;
            end else begin
                w_lenLoad = 1'b1;
                w_r1      = w_idleBit;
            end
        end else if (io_Command == 6'd17) begin
            if (r_idle) begin
                w_r1 = 8'h05;
            end else begin
                w_r1      = 8'h00;
                w_readArm = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_WAIT;
            r_idle      <= 1'b1;
            r_app       <= 1'b0;
            r_blockLen  <= LP_DEF_LEN;
            r_curLen    <= LP_DEF_LEN;
            r_index     <= 12'd0;
            r_count     <= 8'd0;
            r_r1        <= 8'hFF;
            r_isCmd8    <= 1'b0;
            r_readArmed <= 1'b0;
            r_arg       <= 32'd0;
            r_txData    <= 8'hFF;
            r_txValid   <= 1'b0;
            r_memReq    <= 1'b0;
            r_memAddr   <= 32'd0;
        end else if (!io_CsActive) begin
            // Deselect abandons the transaction; any ack arriving now is simply ignored.
            r_state   <= S_WAIT;
            r_txValid <= 1'b0;
            r_txData  <= 8'hFF;
            r_memReq  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (io_CommandValid) begin
                        r_r1        <= w_r1;
                        r_idle      <= w_nextIdle;
                        r_app       <= w_nextApp;
                        r_isCmd8    <= w_isCmd8;
                        r_readArmed <= w_readArm;
                        r_arg       <= io_CommandArgument;
                        if (w_lenLoad) begin
                            r_blockLen <= io_CommandArgument[11:0];
                        end
                        r_txValid <= 1'b1;
                        if (NCR_BYTES > 0) begin
                            r_state  <= S_NCR;
                            r_count  <= LP_NCR;
                            r_txData <= 8'hFF;
                        end else begin
                            r_state  <= S_RESP;
                            r_txData <= w_r1;
                        end
                    end
                end
                S_NCR: begin
                    if (w_accept) begin
                        r_count <= r_count - 8'd1;
                        if (r_count == 8'd1) begin
                            r_state  <= S_RESP;
                            r_txData <= r_r1;
                        end
                    end
                end
                S_RESP: begin
                    if (w_accept) begin
                        if (r_isCmd8) begin
                            r_state  <= S_R7TAIL;
                            r_count  <= 8'd0;
                            r_txData <= 8'h00;
                        end else if (r_readArmed) begin
                            if (NAC_BYTES > 0) begin
                                r_state  <= S_NAC;
                                r_count  <= LP_NAC;
                                r_txData <= 8'hFF;
                            end else begin
                                r_state  <= S_TOKEN;
                                r_txData <= 8'hFE;
                                r_curLen <= r_blockLen;
                            end
                        end else begin
                            r_state   <= S_WAIT;
                            r_txValid <= 1'b0;
                            r_txData  <= 8'hFF;
                        end
                    end
                end
                S_R7TAIL: begin
                    if (w_accept) begin
                        if (r_count == 8'd3) begin
                            r_state   <= S_WAIT;
                            r_txValid <= 1'b0;
                            r_txData  <= 8'hFF;
                        end else begin
                            r_count  <= r_count + 8'd1;
                            r_txData <= r7Byte(r_count[1:0] + 2'd1, r_arg[11:0]);
                        end
                    end
                end
                S_NAC: begin
                    if (w_accept) begin
                        r_count <= r_count - 8'd1;
                        if (r_count == 8'd1) begin
                            r_state  <= S_TOKEN;
                            r_txData <= 8'hFE;
                            r_curLen <= r_blockLen;
                        end
                    end
                end
                S_TOKEN: begin
                    if (w_accept) begin
                        r_state   <= S_FETCH;
                        r_index   <= 12'd0;
                        r_txValid <= 1'b0;
                        r_txData  <= 8'hFF;
                        r_memReq  <= 1'b1;
                        r_memAddr <= r_arg;
                    end
                end
                S_FETCH: begin
                    if (io_MemAck) begin
                        r_state   <= S_SEND;
                        r_memReq  <= 1'b0;
                        r_txData  <= io_MemData;
                        r_txValid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_accept) begin
                        if (r_index == r_curLen - 12'd1) begin
                            r_state  <= S_CRC;
                            r_count  <= 8'd2;
                            r_txData <= 8'hFF;
                        end else begin
                            r_state   <= S_FETCH;
                            r_index   <= r_index + 12'd1;
                            r_txValid <= 1'b0;
                            r_txData  <= 8'hFF;
                            r_memReq  <= 1'b1;
                            r_memAddr <= r_arg + {20'd0, r_index + 12'd1};
                        end
                    end
                end
                S_CRC: begin
                    if (w_accept) begin
                        r_count <= r_count - 8'd1;
                        if (r_count == 8'd1) begin
                            r_state   <= S_WAIT;
                            r_txValid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= S_WAIT;
                    r_txValid <= 1'b0;
                    r_txData  <= 8'hFF;
                    r_memReq  <= 1'b0;
                end
            endcase
        end
    end

    assign io_TxData      = r_txData;
    assign io_TxValid     = r_txValid;
    assign io_MemReq      = r_memReq;
    assign io_MemAddr     = r_memAddr;
    assign io_BlockLength = r_blockLen;
    assign io_Idle        = r_idle;
    assign io_Busy        = (r_state != S_WAIT);

endmodule

// File: tb/tb_sd_spi_command_sequencer.sv
// Scoreboard bench for sd_spi_command_sequencer: a card-level model queues the
// expected byte stream and memory addresses, and monitors pop and compare them.
module tb_sd_spi_command_sequencer;

    localparam int NCR    = 1;
    localparam int NAC    = 2;
    localparam int MAXLEN = 2048;
    localparam int DEFLEN = 512;

    logic        clock;
    logic        reset;
    logic        io_CommandValid;
    logic        io_CommandCrcOk;
    logic [5:0]  io_Command;
    logic [31:0] io_CommandArgument;
    logic        io_CsActive;
    logic [7:0]  io_TxData;
    logic        io_TxValid;
    logic        io_TxReady;
    logic        io_MemReq;
    logic [31:0] io_MemAddr;
    logic [7:0]  io_MemData;
    logic        io_MemAck;
    logic [11:0] io_BlockLength;
    logic        io_Idle;
    logic        io_Busy;

    int          assertCount = 0;
    int          failCount   = 0;
    int          poppedCount = 0;
    logic [7:0]  expQ[$];
    logic [31:0] addrQ[$];
    bit          mIdle = 1'b1;
    bit          mApp  = 1'b0;
    int          mLen  = DEFLEN;
    int          readyMode = 0;
    bit          memRandom = 1'b0;
    int          memDelay  = 2;

    sd_spi_command_sequencer #(
        .DEFAULT_BLOCK_LEN(DEFLEN),
        .MAX_BLOCK_LEN(MAXLEN),
        .NCR_BYTES(NCR),
        .NAC_BYTES(NAC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io_CommandValid(io_CommandValid),
        .io_CommandCrcOk(io_CommandCrcOk),
        .io_Command(io_Command),
        .io_CommandArgument(io_CommandArgument),
        .io_CsActive(io_CsActive),
        .io_TxData(io_TxData),
        .io_TxValid(io_TxValid),
        .io_TxReady(io_TxReady),
        .io_MemReq(io_MemReq),
        .io_MemAddr(io_MemAddr),
        .io_MemData(io_MemData),
        .io_MemAck(io_MemAck),
        .io_BlockLength(io_BlockLength),
        .io_Idle(io_Idle),
        .io_Busy(io_Busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] memFn(input logic [31:0] a);
        return a[7:0] ^ a[23:16];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: timed out, got no completion, expected completion", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Card-level reference: response bytes, R7 echo and read data derived from the command rules.
    function automatic void modelCommand(input bit crcOk, input logic [5:0] cmd, input logic [31:0] arg);
        logic [7:0]  i8;
        logic [7:0]  r1;
        logic [31:0] a;
        bit          tail;
        bit          rd;
        i8   = {7'd0, mIdle};
        tail = 1'b0;
        rd   = 1'b0;
        for (int k = 0; k < NCR; k++) expQ.push_back(8'hFF);
        if (!crcOk) begin
            r1 = 8'h08 | i8;
        end else begin
            if (cmd == 6'd0) begin
                mIdle = 1'b1;
                r1    = 8'h01;
            end else if (cmd == 6'd8) begin
                r1   = i8;
                tail = 1'b1;
            end else if (cmd == 6'd55) begin
                r1 = i8;
            end else if (cmd == 6'd41 && mApp) begin
                mIdle = 1'b0;
                r1    = 8'h00;
            end else if (cmd == 6'd16) begin
                if (arg == 32'd0 || arg > 32'(MAXLEN)) begin
                    r1 = 8'h40 | i8;
                end else begin
                    mLen = int'(arg);
                    r1   = i8;
                end
            end else if (cmd == 6'd17) begin
                if (mIdle) begin
                    r1 = 8'h05;
                end else begin
                    r1 = 8'h00;
                    rd = 1'b1;
                end
            end else begin
                r1 = 8'h04 | i8;
            end
            mApp = (cmd == 6'd55);
        end
        expQ.push_back(r1);
        if (tail) begin
            expQ.push_back(8'h00);
            expQ.push_back(8'h00);
            expQ.push_back({4'h0, arg[11:8]});
            expQ.push_back(arg[7:0]);
        end
        if (rd) begin
            for (int k = 0; k < NAC; k++) expQ.push_back(8'hFF);
            expQ.push_back(8'hFE);
            for (int k = 0; k < mLen; k++) begin
                a = arg + 32'(k);
                expQ.push_back(memFn(a));
                addrQ.push_back(a);
            end
            expQ.push_back(8'hFF);
            expQ.push_back(8'hFF);
        end
    endfunction

    // Sole driver of io_TxReady, updated just after the stimulus writes readyMode.
    initial begin
        io_TxReady = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            case (readyMode)
                0:       io_TxReady = 1'b1;
                1:       io_TxReady = 1'b0;
                default: io_TxReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Byte-wide memory with programmable latency; each request's address is checked against the model.
    initial begin
        int waitCnt;
        int target;
        waitCnt    = 0;
        target     = 2;
        io_MemAck  = 1'b0;
        io_MemData = 8'h00;
        forever begin
            @(posedge clock);
            #1;
            io_MemAck = 1'b0;
            if (io_MemReq && reset) begin
                if (waitCnt == 0) target = memRandom ? int'($urandom_range(0, 3)) : memDelay;
                if (waitCnt >= target) begin
                    io_MemAck  = 1'b1;
                    io_MemData = memFn(io_MemAddr);
                    if (addrQ.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL memAddr: got request 0x%0h, expected no request", io_MemAddr);
                    end else begin
                        checkOutput("memAddr", io_MemAddr, addrQ.pop_front());
                    end
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Transmit monitor: every accepted byte is compared with the head of the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && io_TxValid && io_TxReady) begin
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL txUnexpected: got 0x%02h, expected no byte", io_TxData);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("txByte", io_TxData, e);
                end
                poppedCount++;
            end
        end
    end

    task automatic applyStimulus(input bit crcOk, input logic [5:0] cmd, input logic [31:0] arg);
        io_CommandValid    = 1'b1;
        io_CommandCrcOk    = crcOk;
        io_Command         = cmd;
        io_CommandArgument = arg;
        modelCommand(crcOk, cmd, arg);
        tick(1);
        io_CommandValid    = 1'b0;
        io_CommandCrcOk    = 1'($urandom);
        io_Command         = 6'($urandom);
        io_CommandArgument = $urandom;
    endtask

    task automatic waitDone(input string name);
        int c;
        c = 0;
        while ((io_Busy || expQ.size() != 0) && c < 8000) begin
            tick(1);
            c++;
        end
        if (c >= 8000) begin
            reportTimeout(name);
            expQ.delete();
            addrQ.delete();
        end
    endtask

    task automatic runCommand(input string name, input bit crcOk, input logic [5:0] cmd, input logic [31:0] arg);
        applyStimulus(crcOk, cmd, arg);
        waitDone(name);
        checkOutput({name, ".idle"}, 32'(io_Idle), 32'(mIdle));
        checkOutput({name, ".blockLen"}, 32'(io_BlockLength), 32'(mLen));
        checkOutput({name, ".txValid"}, 32'(io_TxValid), 32'd0);
    endtask

    task automatic waitForBytes(input int target, input string name);
        int c;
        c = 0;
        while (!(poppedCount >= target && io_TxValid) && c < 2000) begin
            tick(1);
            c++;
        end
        if (c >= 2000) reportTimeout(name);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, ".txValid"}, 32'(io_TxValid), 32'd0);
        checkOutput({name, ".txData"}, 32'(io_TxData), 32'hFF);
        checkOutput({name, ".memReq"}, 32'(io_MemReq), 32'd0);
        checkOutput({name, ".memAddr"}, io_MemAddr, 32'd0);
        checkOutput({name, ".busy"}, 32'(io_Busy), 32'd0);
        checkOutput({name, ".idle"}, 32'(io_Idle), 32'd1);
        checkOutput({name, ".blockLen"}, 32'(io_BlockLength), 32'(DEFLEN));
    endtask

    initial begin
        int base;
        int sel;
        bit crc;
        logic [5:0]  cmd;
        logic [31:0] arg;

        reset              = 1'b0;
        io_CsActive        = 1'b1;
        io_CommandValid    = 1'b0;
        io_CommandCrcOk    = 1'b0;
        io_Command         = 6'd0;
        io_CommandArgument = 32'd0;
        tick(3);
        checkResetValues("reset");
        reset = 1'b1;
        tick(1);

        runCommand("cmd0", 1'b1, 6'd0, 32'd0);
        runCommand("cmd17Idle", 1'b1, 6'd17, 32'h100);
        runCommand("cmd8", 1'b1, 6'd8, 32'h0000_01AA);
        runCommand("cmd41NoApp", 1'b1, 6'd41, 32'd0);
        runCommand("cmd55", 1'b1, 6'd55, 32'd0);
        runCommand("acmd41", 1'b1, 6'd41, 32'h4000_0000);
        runCommand("cmd16Max", 1'b1, 6'd16, 32'd2048);
        runCommand("cmd16Over", 1'b1, 6'd16, 32'd2049);
        runCommand("cmd16Len4", 1'b1, 6'd16, 32'd4);
        memDelay = 2;
        runCommand("cmd17Read", 1'b1, 6'd17, 32'h100);
        runCommand("cmd16Big", 1'b1, 6'd16, 32'd4096);
        runCommand("cmd16Zero", 1'b1, 6'd16, 32'd0);
        runCommand("crcBad", 1'b0, 6'd17, 32'h100);
        runCommand("cmd17Wrap", 1'b1, 6'd17, 32'hFFFF_FFFE);

        // Backpressure mid-block, with a stray command pulse that must be ignored.
        runCommand("cmd16Len8", 1'b1, 6'd16, 32'd8);
        base = poppedCount;
        applyStimulus(1'b1, 6'd17, 32'h2000);
        waitForBytes(base + 7, "stallWait");
        readyMode = 1;
        io_CommandValid = 1'b1;
        io_CommandCrcOk = 1'b1;
        io_Command      = 6'd0;
        tick(1);
        io_CommandValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("stallValid", 32'(io_TxValid), 32'd1);
            checkOutput("stallData", 32'(io_TxData), 32'(expQ[0]));
            if (k < 4) tick(1);
        end
        readyMode = 0;
        waitDone("stallRead");
        checkOutput("stall.idle", 32'(io_Idle), 32'(mIdle));

        // Chip-select drop during SEND, then a fresh read from index 0.
        base = poppedCount;
        applyStimulus(1'b1, 6'd17, 32'h3000);
        waitForBytes(base + 6, "abortWait");
        io_CsActive = 1'b0;
        readyMode   = 1;
        tick(1);
        checkOutput("abort.txValid", 32'(io_TxValid), 32'd0);
        checkOutput("abort.memReq", 32'(io_MemReq), 32'd0);
        checkOutput("abort.busy", 32'(io_Busy), 32'd0);
        tick(2);
        expQ.delete();
        addrQ.delete();
        io_CsActive = 1'b1;
        readyMode   = 0;
        tick(1);
        checkOutput("abort.idle", 32'(io_Idle), 32'(mIdle));
        checkOutput("abort.blockLen", 32'(io_BlockLength), 32'(mLen));
        runCommand("cmd17AfterAbort", 1'b1, 6'd17, 32'h3000);

        // Bad CRC while idle must not set the app prefix.
        runCommand("cmd0b", 1'b1, 6'd0, 32'd0);
        runCommand("crcBadIdle", 1'b0, 6'd55, 32'd0);
        runCommand("cmd41AfterBadCrc", 1'b1, 6'd41, 32'd0);

        // Reset in the middle of a block read.
        runCommand("cmd55r", 1'b1, 6'd55, 32'd0);
        runCommand("acmd41r", 1'b1, 6'd41, 32'd0);
        runCommand("cmd16Len6", 1'b1, 6'd16, 32'd6);
        base = poppedCount;
        applyStimulus(1'b1, 6'd17, 32'h40);
        waitForBytes(base + 6, "resetWait");
        reset = 1'b0;
        tick(2);
        checkResetValues("midReset");
        expQ.delete();
        addrQ.delete();
        mIdle = 1'b1;
        mApp  = 1'b0;
        mLen  = DEFLEN;
        reset = 1'b1;
        tick(1);

        // Randomized command mix under random backpressure and memory latency.
        readyMode = 2;
        memRandom = 1'b1;
        runCommand("rndCmd0", 1'b1, 6'd0, 32'd0);
        runCommand("rndLen", 1'b1, 6'd16, 32'($urandom_range(1, 16)));
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            crc = ($urandom_range(0, 9) != 0);
            arg = $urandom;
            case (sel)
                0:       cmd = 6'd0;
                1:       cmd = 6'd8;
                2, 3:    cmd = 6'd55;
                4:       cmd = 6'd41;
                5: begin
                    cmd = 6'd16;
                    arg = 32'($urandom_range(1, 16));
                end
                6: begin
                    cmd = 6'd16;
                    arg = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'(MAXLEN + 1) + 32'($urandom_range(0, 5000));
                end
                7, 8:    cmd = 6'd17;
                default: begin
                    cmd = 6'($urandom_range(0, 63));
                    if (cmd == 6'd16 || cmd == 6'd17) cmd = 6'd63;
                end
            endcase
            runCommand("rnd", crc, cmd, arg);
        end
        readyMode = 0;
        memRandom = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no end of test, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sd_spi_command_sequencer.md
Name: sd_spi_command_sequencer

Overview:
- Controller behind the SPI command receiver in the SD-card SPI-mode slave.
- Consumes each fully parsed command (index, 32-bit argument, CRC status) and tracks card state (idle/ready, app-command prefix, block length).
- Generates the R1/R7 response byte stream to the SPI transmitter.
- Sequences single-block reads (CMD17): fetches bytes from a byte-wide memory port and emits start token, data block and CRC bytes.

Parameters:
DEFAULT_BLOCK_LEN, 512, block length after reset (bytes)
MAX_BLOCK_LEN, 2048, largest length accepted by CMD16
NCR_BYTES, 1, 0xFF fill bytes between command end and response
NAC_BYTES, 2, 0xFF fill bytes between R1 and data token

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
io_CommandValid  in  1  one-cycle pulse: command frame complete
io_CommandCrcOk  in  1  CRC result, qualified by io_CommandValid
io_Command  in  6  command index, qualified by io_CommandValid
io_CommandArgument  in  32  argument, qualified by io_CommandValid
io_CsActive  in  1  chip select asserted (already active-high)
io_TxData  out  8  byte to transmit
io_TxValid  out  1  io_TxData valid
io_TxReady  in  1  transmitter accepts byte
io_MemReq  out  1  memory read request
io_MemAddr  out  32  byte address
io_MemData  in  8  read data, valid with io_MemAck
io_MemAck  in  1  one-cycle read completion
io_BlockLength  out  12  current block length
io_Idle  out  1  card in idle state (R1 bit 0)
io_Busy  out  1  sequencer not in WAIT

Behaviour:
- Reset (reset==0 at a clock edge) values:
  - state WAIT, io_Idle=1, app flag=0, io_BlockLength=DEFAULT_BLOCK_LEN.
  - io_TxValid=0, io_TxData=0xFF, io_MemReq=0, io_MemAddr=0, io_Busy=0.
- States: WAIT, NCR, RESP, R7TAIL, NAC, TOKEN, FETCH, SEND, CRC.
- Byte handshake: a byte transfers on a cycle with io_TxValid&io_TxReady. io_TxData is stable while io_TxValid=1 and not yet accepted.
- WAIT: when io_CommandValid=1, decode and latch the response, then go to NCR with counter=NCR_BYTES. io_CommandValid in any other state is ignored.
- Decode, in priority order. `I` denotes the current io_Idle value.
  - CRC bad: R1=0x08|I, no state change.
  - CMD0: io_Idle<=1, app<=0, R1=0x01.
  - CMD8: R1=I, then R7TAIL sends 4 bytes 0x00,0x00, {4'h0,arg[11:8]}, arg[7:0].
  - CMD55: app<=1, R1=I.
  - ACMD41 (app=1): io_Idle<=0, R1=0x00.
  - CMD16:
    - arg==0 or arg>MAX_BLOCK_LEN: R1=0x40|I, length unchanged.
    - otherwise: length<=arg[11:0], R1=I.
  - CMD17:
    - io_Idle=1: R1=0x05.
    - otherwise: R1=0x00, read sequence armed.
  - Anything else: R1=0x04|I.
  - App flag clears on every command except CMD55.
- NCR: send 0xFF counter times, then RESP.
- RESP: send R1. After acceptance go to:
  - R7TAIL if CMD8;
  - NAC (counter=NAC_BYTES) if CMD17 was armed;
  - WAIT otherwise.
- NAC: send 0xFF NAC_BYTES times, then TOKEN.
- TOKEN: send 0xFE, reset byte index to 0, then FETCH.
- FETCH:
  - io_MemReq=1 with io_MemAddr=arg+index (32-bit wrap) until io_MemAck.
  - Data latched on io_MemAck, go to SEND. io_MemReq drops the cycle after the ack.
- SEND:
  - Present the latched byte.
  - On acceptance, index+1. If index==io_BlockLength-1, go to CRC; else go to FETCH.
- CRC: send 0xFF, 0xFF (CRC unchecked in SPI mode), then WAIT.
- io_BlockLength is sampled when TOKEN is entered; a length change cannot occur mid-block.
- CS abort: io_CsActive=0 in any state forces WAIT next cycle.
  - io_TxValid and io_MemReq drop; a pending memory ack is discarded.
  - io_Idle, app flag and block length are retained.
- Reset mid-operation: reset has priority over everything; all registers take reset values.
- io_Busy=1 in every state except WAIT.

Test Plan:
- Reset, then CMD0 (crc ok) with io_TxReady=1 -> bytes 0xFF, 0x01; io_Idle=1, io_Busy returns 0.
- CMD8 arg=0x000001AA -> 0xFF, 0x01, 0x00, 0x00, 0x01, 0xAA.
- CMD55 then ACMD41 -> responses 0x01, then 0x00; io_Idle=0. CMD41 without a preceding CMD55 -> 0x05.
- CMD16 arg=4, then CMD17 arg=0x100 with memory returning addr[7:0] after a 2-cycle delay -> stream 0xFF, 0x00, 0xFF, 0xFF, 0xFE, 0x00, 0x01, 0x02, 0x03, 0xFF, 0xFF; io_MemAddr runs 0x100 through 0x103.
- CMD16 arg=4096 -> 0x40, length stays 4. Any command with io_CommandCrcOk=0 -> 0x08 (0x09 if idle).
- io_TxReady held low 5 cycles mid-block -> io_TxData stable, no byte lost. Drop io_CsActive during SEND -> WAIT next cycle, io_TxValid=0. A following CMD17 restarts the stream at index 0.
